cam_buffer_io: RTL and testbench

Camera-side support block for the OV7670 capture path. It contains:
- a 1024×16 pixel FIFO between the capture FSM (writer) and the SDRAM/display side (reader), both in the `clk_100` domain;
- four pushbutton debouncers producing level and single-cycle tick outputs for brightness/contrast control;
- a fractional-divider camera XCLK generator.

It replaces the separate FIFO, debounce and clock-manager instances around the capture FSM.

---
 rtl/cam_buffer_io_pkg.sv | 24 ++
 rtl/cam_buffer_io_key_debounce.sv | 83 ++++++++
 rtl/cam_buffer_io.sv | 122 ++++++++++++
 tb/tb_cam_buffer_io.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_buffer_io_pkg.sv
// Shared constants and types for the OV7670 camera support block:
// FIFO geometry, debounce timing, XCLK phase step and debounce FSM states.
package cam_buffer_io_pkg;

    localparam int          CAM_DATA_WIDTH       = 16;
    localparam int          CAM_FIFO_DEPTH_WIDTH = 10;
    localparam int          CAM_DB_CYCLES        = 2_000_000;
    localparam logic [31:0] CAM_XCLK_STEP        = 32'h1EB851EC;
    localparam int          CAM_NUM_KEYS         = 4;
    localparam int          CAM_LOCK_CYCLES      = 16;

    typedef enum logic [1:0] {
        DB_ZERO  = 2'd0,
        DB_WAIT1 = 2'd1,
        DB_ONE   = 2'd2,
        DB_WAIT0 = 2'd3
    } db_state_t;

    // Counter must be at least one bit wide even for degenerate DB_CYCLES.
    function automatic int db_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/cam_buffer_io_key_debounce.sv
// Single pushbutton debouncer: 2-FF synchronizer, four-state FSM with a
// stability counter, debounced level and a registered press tick.
module key_debounce
    import cam_buffer_io_pkg::*;
#(
    parameter int DB_CYCLES = CAM_DB_CYCLES
) (
    input  logic clk_100,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_level,
    output logic o_tick
);

    localparam int            CW       = db_cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    r_sync;
    db_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic          w_sw;

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], ~i_key_n};
        end
    end

    assign w_sw = r_sync[1];

    // The tick fires only on the WAIT1->ONE edge; a bounce back from WAIT0 is silent.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DB_ZERO;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                DB_ZERO: begin
                    if (w_sw) begin
                        r_state <= DB_WAIT1;
                        r_cnt   <= '0;
                    end
                end
                DB_WAIT1: begin
                    if (!w_sw) begin
                        r_state <= DB_ZERO;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= DB_ONE;
                        r_tick  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                DB_ONE: begin
                    if (!w_sw) begin
                        r_state <= DB_WAIT0;
                        r_cnt   <= '0;
                    end
                end
                DB_WAIT0: begin
                    if (w_sw) begin
                        r_state <= DB_ONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= DB_ZERO;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_state <= DB_ZERO;
            endcase
        end
    end

    assign o_level = (r_state == DB_ONE) || (r_state == DB_WAIT0);
    assign o_tick  = r_tick;

endmodule

// File: rtl/cam_buffer_io.sv
// Camera-side support block: pixel FIFO, four key debouncers and the XCLK
// generator. Define CAM_XCLK_GEN_EN to build the internal XCLK accumulator.
module cam_buffer_io
    import cam_buffer_io_pkg::*;
#(
    parameter int DATA_WIDTH       = CAM_DATA_WIDTH,
    parameter int FIFO_DEPTH_WIDTH = CAM_FIFO_DEPTH_WIDTH,
    parameter int DB_CYCLES        = CAM_DB_CYCLES
`ifdef CAM_XCLK_GEN_EN
    ,
    parameter logic [31:0] XCLK_STEP = CAM_XCLK_STEP
`endif
) (
    input  logic                        clk_100,
    input  logic                        rst_n,
    input  logic [CAM_NUM_KEYS-1:0]     key,
    output logic [CAM_NUM_KEYS-1:0]     key_level,
    output logic [CAM_NUM_KEYS-1:0]     key_tick,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [FIFO_DEPTH_WIDTH-1:0] data_count_r,
    output logic                        cmos_xclk,
    output logic                        xclk_locked
);

    localparam int                    AW      = FIFO_DEPTH_WIDTH;
    localparam int                    DEPTH   = 1 << AW;
    localparam logic [AW:0]           PTR_ONE = (AW + 1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [AW:0]           w_diff;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_ok;
    logic                  w_rd_ok;

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_wr_ok = wr_en && !w_full;
    assign w_rd_ok = rd_en && !w_empty;
    assign w_diff  = r_wr_ptr - r_rd_ptr;

    // Storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk_100) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    assign rd_data      = r_rd_data;
    assign full         = w_full;
    assign empty        = w_empty;
    assign data_count_r = w_diff[AW-1:0];

    for (genvar g = 0; g < CAM_NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_key_debounce (
            .clk_100 (clk_100),
            .rst_n   (rst_n),
            .i_key_n (key[g]),
            .o_level (key_level[g]),
            .o_tick  (key_tick[g])
        );
    end

`ifdef CAM_XCLK_GEN_EN
    localparam logic [4:0] LOCK_LAST = 5'(CAM_LOCK_CYCLES - 1);
    localparam logic [4:0] LOCK_ONE  = 5'd1;

    logic [31:0] r_acc;
    logic [4:0]  r_lock_cnt;
    logic        r_locked;

    // Phase accumulator: the MSB toggles at the average ratio step/2^32.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_acc <= r_acc + XCLK_STEP;
            if (!r_locked) begin
                r_lock_cnt <= r_lock_cnt + LOCK_ONE;
                if (r_lock_cnt == LOCK_LAST) begin
                    r_locked <= 1'b1;
                end
            end
        end
    end

    assign cmos_xclk   = r_acc[31];
    assign xclk_locked = r_locked;
`else
    assign cmos_xclk   = 1'b0;
    assign xclk_locked = 1'b1;
`endif

endmodule

// File: tb/tb_cam_buffer_io.sv
// Self-checking bench for cam_buffer_io: FIFO against a queue model, key
// debounce timing with DB_CYCLES=16, XCLK edge rate and async reset.
module tb_cam_buffer_io;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int DB    = 16;

    logic          clk_100;
    logic          rst_n;
    logic [3:0]    key;
    logic [3:0]    key_level;
    logic [3:0]    key_tick;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
    logic [AW-1:0] data_count_r;
    logic          cmos_xclk;
    logic          xclk_locked;

    int testCount = 0;
    int failCount = 0;

    cam_buffer_io #(
        .DATA_WIDTH       (DW),
        .FIFO_DEPTH_WIDTH (AW),
        .DB_CYCLES        (DB)
    ) dut (
        .clk_100      (clk_100),
        .rst_n        (rst_n),
        .key          (key),
        .key_level    (key_level),
        .key_tick     (key_tick),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .data_count_r (data_count_r),
        .cmos_xclk    (cmos_xclk),
        .xclk_locked  (xclk_locked)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    task automatic step();
        @(posedge clk_100);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        key = 4'hF;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = '0;
        rst_n = 1'b0;
        #3;
        testCount++;
        if (empty !== 1'b1 || full !== 1'b0 || data_count_r !== '0 || rd_data !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_fifo: empty=%b full=%b count=%0d rd=%h, required 1 0 0 0000",
                     empty, full, data_count_r, rd_data);
        end
        testCount++;
        if (key_level !== 4'h0 || key_tick !== 4'h0 || cmos_xclk !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_keys_xclk: level=%h tick=%h xclk=%b, required 0 0 0",
                     key_level, key_tick, cmos_xclk);
        end
        testCount++;
`ifdef CAM_XCLK_GEN_EN
        if (xclk_locked !== 1'b0) begin
`else
        if (xclk_locked !== 1'b1) begin
`endif
            failCount++;
            $display("[TB] FAIL reset_locked: got %b", xclk_locked);
        end
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_xclk();
        int  rises = 0;
        int  lockBad = 0;
        logic prev;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        prev = cmos_xclk;
        for (int c = 1; c <= 10000; c++) begin
            step();
            if (cmos_xclk === 1'b1 && prev === 1'b0) rises++;
            prev = cmos_xclk;
`ifdef CAM_XCLK_GEN_EN
            if (c == 10) begin
                testCount++;
                if (xclk_locked !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL xclk_early_lock: got %b at cycle 10, required 0", xclk_locked);
                end
            end
`endif
            if (c >= 16 && xclk_locked !== 1'b1) lockBad++;
        end
        testCount++;
        if (lockBad != 0) begin
            failCount++;
            $display("[TB] FAIL xclk_locked: low in %0d cycles from cycle 16, required 0", lockBad);
        end
        testCount++;
`ifdef CAM_XCLK_GEN_EN
        if (rises < 1199 || rises > 1201) begin
            failCount++;
            $display("[TB] FAIL xclk_rate: %0d rising edges, required 1200 +-1", rises);
        end
`else
        if (rises != 0) begin
            failCount++;
            $display("[TB] FAIL xclk_tied: %0d rising edges, required 0", rises);
        end
`endif
    endtask

    task automatic test_fill_drain();
        int bad = 0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1;
            wr_data = DW'(i);
            step();
        end
        wr_en = 1'b0;
        testCount++;
        if (full !== 1'b1 || empty !== 1'b0 || data_count_r !== '0) begin
            failCount++;
            $display("[TB] FAIL fill_full: full=%b empty=%b count=%0d, required 1 0 0", full, empty, data_count_r);
        end
        wr_en = 1'b1;
        wr_data = 16'hDEAD;
        step();
        wr_en = 1'b0;
        testCount++;
        if (full !== 1'b1 || data_count_r !== '0) begin
            failCount++;
            $display("[TB] FAIL write_when_full: full=%b count=%0d, required 1 0", full, data_count_r);
        end
        // full + simultaneous request: read only
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 16'hBEEF;
        step();
        wr_en = 1'b0;
        testCount++;
        if (rd_data !== 16'h0000 || data_count_r !== 10'd1023 || full !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL full_rdwr: rd=%h count=%0d full=%b, required 0000 1023 0", rd_data, data_count_r, full);
        end
        for (int i = 1; i < DEPTH; i++) begin
            step();
            if (rd_data !== DW'(i)) begin
                bad++;
                if (bad < 5) $display("[TB] FAIL drain_data: got %h required %h", rd_data, DW'(i));
            end
        end
        rd_en = 1'b0;
        testCount++;
        if (bad != 0) begin
            failCount++;
            $display("[TB] FAIL drain_order: %0d wrong words, required 0", bad);
        end
        testCount++;
        if (empty !== 1'b1 || data_count_r !== '0) begin
            failCount++;
            $display("[TB] FAIL drain_empty: empty=%b count=%0d, required 1 0", empty, data_count_r);
        end
        // empty + simultaneous request: write only
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 16'h1234;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        testCount++;
        if (data_count_r !== 10'd1 || rd_data !== 16'h03FF || empty !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL empty_rdwr: count=%0d rd=%h empty=%b, required 1 03ff 0", data_count_r, rd_data, empty);
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        testCount++;
        if (rd_data !== 16'h1234 || empty !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL empty_rdwr_word: rd=%h empty=%b, required 1234 1", rd_data, empty);
        end
    endtask

    task automatic test_random_fifo();
        logic [DW-1:0] q[$];
        logic [DW-1:0] expRd = '0;
        logic          w;
        logic          r;
        logic [DW-1:0] d;
        int            bad = 0;
        int            sawFull = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c < 1500) begin
                w = ($urandom_range(0, 99) < 95);
                r = ($urandom_range(0, 99) < 10);
            end else begin
                w = ($urandom_range(0, 99) < 10);
                r = ($urandom_range(0, 99) < 95);
            end
            d = DW'($urandom);
            wr_en = w;
            rd_en = r;
            wr_data = d;
            begin
                int pre = q.size();
                if (r && pre > 0) expRd = q.pop_front();
                if (w && pre < DEPTH) q.push_back(d);
            end
            step();
            if (q.size() == DEPTH) sawFull++;
            testCount++;
            if (rd_data !== expRd || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)
                || data_count_r !== AW'(q.size() % DEPTH)) begin
                failCount++;
                bad++;
                if (bad < 6)
                    $display("[TB] FAIL random_fifo c=%0d: rd=%h empty=%b full=%b count=%0d, required %h %b %b %0d",
                             c, rd_data, empty, full, data_count_r, expRd, q.size() == 0,
                             q.size() == DEPTH, q.size() % DEPTH);
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (sawFull == 0) $display("[TB] note: random run did not reach full");
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            wr_en = 1'b1;
            wr_data = DW'(16'h1000 + i);
            step();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        testCount++;
        if (rd_data !== 16'h1000 || data_count_r !== 10'd99) begin
            failCount++;
            $display("[TB] FAIL pre_reset: rd=%h count=%0d, required 1000 99", rd_data, data_count_r);
        end
        #2;
        rst_n = 1'b0;
        #1;
        testCount++;
        if (empty !== 1'b1 || data_count_r !== '0 || rd_data !== '0 || full !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL async_reset: empty=%b count=%0d rd=%h full=%b, required 1 0 0000 0",
                     empty, data_count_r, rd_data, full);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_debounce();
        int ticks = 0;
        int firstTick = -1;
        int levelSeen = 0;
        int otherSeen = 0;
        int dropAt = -1;
        do_reset();
        key = 4'hF;
        for (int n = 0; n < 6; n++) begin
            int len = (n == 0) ? 10 : $urandom_range(1, 12);
            key[2] = 1'b0;
            for (int c = 0; c < len; c++) begin
                step();
                if (key_tick[2]) ticks++;
                if (key_level[2]) levelSeen++;
            end
            key[2] = 1'b1;
            for (int c = 0; c < 25; c++) begin
                step();
                if (key_tick[2]) ticks++;
                if (key_level[2]) levelSeen++;
            end
        end
        testCount++;
        if (ticks != 0 || levelSeen != 0) begin
            failCount++;
            $display("[TB] FAIL glitch: ticks=%0d level-high cycles=%0d, required 0 0", ticks, levelSeen);
        end
        key[2] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (key_tick[2]) begin
                ticks++;
                if (firstTick < 0) firstTick = c;
            end
            if (key_level[0] || key_level[1] || key_level[3]) otherSeen++;
        end
        testCount++;
        if (ticks != 1 || firstTick < 18 || firstTick > 20) begin
            failCount++;
            $display("[TB] FAIL press_tick: ticks=%0d at cycle %0d, required 1 at 19", ticks, firstTick);
        end
        testCount++;
        if (key_level !== 4'b0100 || otherSeen != 0) begin
            failCount++;
            $display("[TB] FAIL press_level: level=%b other=%0d, required 0100 0", key_level, otherSeen);
        end
        key[2] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (key_tick[2]) ticks++;
            if (!key_level[2] && dropAt < 0) dropAt = c;
        end
        testCount++;
        if (dropAt < 18 || dropAt > 20 || ticks != 1) begin
            failCount++;
            $display("[TB] FAIL release: level dropped at cycle %0d ticks=%0d, required 19 1", dropAt, ticks);
        end
    endtask

    task automatic test_bounce_release();
        int ticks = 0;
        int lowSeen = 0;
        key = 4'hF;
        key[0] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (key_tick[0]) ticks++;
        end
        testCount++;
        if (ticks != 1 || key_level[0] !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL bounce_press: ticks=%0d level=%b, required 1 1", ticks, key_level[0]);
        end
        ticks = 0;
        for (int c = 0; c < 80; c++) begin
            key[0] = ((c / 5) % 2 == 0) ? 1'b1 : 1'b0;
            step();
            if (key_tick[0]) ticks++;
            if (!key_level[0]) lowSeen++;
        end
        key[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (key_tick[0]) ticks++;
            if (!key_level[0]) lowSeen++;
        end
        testCount++;
        if (ticks != 0 || lowSeen != 0) begin
            failCount++;
            $display("[TB] FAIL bounce_release: extra ticks=%0d level-low cycles=%0d, required 0 0", ticks, lowSeen);
        end
        key[0] = 1'b1;
        for (int c = 0; c < 30; c++) step();
        testCount++;
        if (key_level !== 4'h0) begin
            failCount++;
            $display("[TB] FAIL final_release: level=%b, required 0000", key_level);
        end
    endtask

    initial begin
        test_reset();
        test_xclk();
        test_fill_drain();
        test_random_fifo();
        test_reset_midstream();
        test_debounce();
        test_bounce_release();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
